// File: rtl/hi_ssp_pkg.sv
// Shared types and constants for the HF reader I/Q correlator -> ARM SSP path.
//   iq_pair_t       : one signed I/Q correlation pair, I in the upper byte
//   ssp_tx_state_t  : serialiser FSM states
//   SSP_WORD_BITS   : bits per serialised pair (two 8-bit SSP frames)
package hi_ssp_pkg;

  localparam int SSP_WORD_BITS = 16;

  typedef struct packed {
    logic signed [7:0] i;
    logic signed [7:0] q;
  } iq_pair_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } ssp_tx_state_t;

endpackage

// File: rtl/hi_sync_fifo.sv
// Small synchronous FIFO. All state updates on the falling edge of clk so it
// lines up with the serialiser, which runs on the falling edge of adc_clk.
// Ports:
//   clk, srst   : clock (falling-edge active) and synchronous active-high reset
//   push, din   : write request and data; accepted when not full, or when full
//                 and a pop happens in the same cycle
//   pop, dout   : read request; dout shows the head entry combinationally
//   full, empty : occupancy flags
//   count       : entries currently held (0..DEPTH)
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
module hi_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;

  // A simultaneous pop frees the head slot, so a push into a full FIFO is
  // still accepted in that cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Depth is tiny, so the head is read combinationally (distributed RAM).
  assign dout = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(negedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(negedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/hi_xcorr_ssp_tx.sv
// Buffers signed I/Q correlation pairs and serialises each one to the ARM SSP
// port as two 8-bit frames (I then Q, MSB first). Pairs arriving while the
// buffer is full are dropped and counted.
// Ports:
//   adc_clk    : sole clock; every state update happens on its falling edge
//   rst        : synchronous active-high reset
//   in_valid   : one-cycle strobe, in_i/in_q hold a new pair
//   in_i, in_q : signed 8-bit I and Q correlations
//   ssp_clk    : SSP bit clock (high for the first half of each bit period)
//   ssp_frame  : high for the whole of bit periods 0 and 8
//   ssp_din    : serial data, stable across each bit period
//   fifo_cnt   : pairs currently buffered
//   drop_cnt   : pairs dropped since reset, saturating at 255
// Optional feature, macro HI_XCORR_SSP_OVF_MARK_EN: after any drop the next
// popped pair goes out with Q bit 0 forced to 1 to flag the sample gap.
module hi_xcorr_ssp_tx
  import hi_ssp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                          adc_clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [7:0]             in_i,
  input  logic signed [7:0]             in_q,
  output logic                          ssp_clk,
  output logic                          ssp_frame,
  output logic                          ssp_din,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic [7:0]                    drop_cnt
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(SSP_WORD_BITS);

  ssp_tx_state_t            state_reg, state_next;
  logic [SSP_WORD_BITS-1:0] shreg_reg, shreg_next;
  logic [BIT_W-1:0]         bit_reg, bit_next;
  logic [DIV_W-1:0]         div_reg, div_next;
  logic [7:0]               drop_cnt_reg;

  iq_pair_t                 in_pair;
  logic [SSP_WORD_BITS-1:0] fifo_dout;
  logic [SSP_WORD_BITS-1:0] load_word;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_pop;
  logic                     drop;

  assign in_pair  = '{i: in_i, q: in_q};
  assign fifo_pop = (state_reg == LOAD);
  assign drop     = in_valid && fifo_full && !fifo_pop;
  assign drop_cnt = drop_cnt_reg;

  hi_sync_fifo #(
    .WIDTH (SSP_WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (adc_clk),
    .srst  (rst),
    .push  (in_valid),
    .din   (in_pair),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

`ifdef HI_XCORR_SSP_OVF_MARK_EN
  // Set by a drop, consumed by the next pop. A drop needs a full FIFO with no
  // pop, so set has priority only for completeness.
  logic mark_reg;

  always_ff @(negedge adc_clk) begin
    if (rst)           mark_reg <= 1'b0;
    else if (drop)     mark_reg <= 1'b1;
    else if (fifo_pop) mark_reg <= 1'b0;
  end

  assign load_word = fifo_dout | {{(SSP_WORD_BITS-1){1'b0}}, mark_reg};
`else
  assign load_word = fifo_dout;
`endif

  always_ff @(negedge adc_clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      bit_reg      <= '0;
      div_reg      <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      bit_reg   <= bit_next;
      div_reg   <= div_next;
      if (drop && drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    bit_next   = bit_reg;
    div_next   = div_reg;
    ssp_clk    = 1'b0;
    ssp_frame  = 1'b0;
    ssp_din    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) state_next = LOAD;
      end
      LOAD: begin
        shreg_next = load_word;
        bit_next   = '0;
        div_next   = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        ssp_clk   = (div_reg < DIV_W'(CLK_DIV/2));
        ssp_frame = (bit_reg == '0) || (bit_reg == BIT_W'(8));
        ssp_din   = shreg_reg[SSP_WORD_BITS-1];
        if (div_reg == DIV_W'(CLK_DIV-1)) begin
          div_next   = '0;
          shreg_next = {shreg_reg[SSP_WORD_BITS-2:0], 1'b0};
          bit_next   = bit_reg + BIT_W'(1);
          // Going straight to LOAD gives exactly one ssp_clk=0 gap cycle.
          if (bit_reg == BIT_W'(SSP_WORD_BITS-1)) begin
            state_next = fifo_empty ? IDLE : LOAD;
          end
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hi_xcorr_ssp_tx.sv
module tb_hi_xcorr_ssp_tx;

  localparam int FIFO_DEPTH = 4;
  localparam int CLK_DIV    = 4;
  localparam int WORD_CYC   = 16 * CLK_DIV;
`ifdef HI_XCORR_SSP_OVF_MARK_EN
  localparam bit MARK_EN = 1'b1;
`else
  localparam bit MARK_EN = 1'b0;
`endif

  logic       adc_clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_i = 8'h00;
  logic [7:0] in_q = 8'h00;
  logic       ssp_clk, ssp_frame, ssp_din;
  logic [2:0] fifo_cnt;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  hi_xcorr_ssp_tx #(.FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .adc_clk   (adc_clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_i      (in_i),
    .in_q      (in_q),
    .ssp_clk   (ssp_clk),
    .ssp_frame (ssp_frame),
    .ssp_din   (ssp_din),
    .fifo_cnt  (fifo_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 adc_clk = ~adc_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: transmitter phase (0 idle, 1 load, 2 shifting) and
  // elapsed cycles within the current word.
  logic [15:0] m_q[$];
  int          m_phase = 0;
  int          m_el = 0;
  logic [15:0] m_word = '0;
  int          m_drop = 0;
  bit          m_mark = 0;
  logic [15:0] exp_words[$];
  int          ex_rd = 0;

  // Receiver acting as the ARM: samples ssp_din on ssp_clk falling edges.
  logic [15:0] rx_words[$];
  logic [15:0] rx_sh = '0;
  int          rx_n = 0;
  int          rx_rd = 0;
  logic        prev_clk = 1'b0;

  always @(posedge adc_clk) begin
    if (rst) begin
      rx_n = 0;
    end else if (prev_clk && !ssp_clk) begin
      rx_sh = {rx_sh[14:0], ssp_din};
      rx_n++;
      if (rx_n == 16) begin
        rx_words.push_back(rx_sh);
        rx_n = 0;
      end
    end
    prev_clk = ssp_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input logic [15:0] d);
    bit          pre_ne, pre_full, pop;
    logic [15:0] w;
    w = '0;
    if (r) begin
      m_q.delete();
      m_phase = 0; m_el = 0; m_drop = 0; m_mark = 0;
      return;
    end
    pre_ne   = (m_q.size() > 0);
    pre_full = (m_q.size() == FIFO_DEPTH);
    pop      = (m_phase == 1);
    if (pop) begin
      w = m_q.pop_front();
      if (MARK_EN && m_mark) w[0] = 1'b1;
      m_mark = 0;
    end
    if (v) begin
      if (!pre_full || pop) m_q.push_back(d);
      else begin
        if (m_drop < 255) m_drop++;
        m_mark = 1;
      end
    end
    case (m_phase)
      0: if (pre_ne) m_phase = 1;
      1: begin m_phase = 2; m_el = 0; m_word = w; end
      default: begin
        m_el++;
        if (m_el == WORD_CYC) begin
          exp_words.push_back(m_word);
          m_phase = pre_ne ? 1 : 0;
        end
      end
    endcase
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] i, input logic [7:0] q);
    int b;
    bit e_clk, e_fr, e_din;
    rst = r; in_valid = v; in_i = i; in_q = q;
    @(negedge adc_clk);
    model(r, v, {i, q});
    @(posedge adc_clk);
    #1;
    e_clk = 0; e_fr = 0; e_din = 0;
    if (m_phase == 2) begin
      b     = m_el / CLK_DIV;
      e_clk = (m_el % CLK_DIV) < (CLK_DIV / 2);
      e_fr  = (b == 0) || (b == 8);
      e_din = m_word[15-b];
    end
    chk("ssp_clk", ssp_clk, e_clk);
    chk("ssp_frame", ssp_frame, e_fr);
    chk("ssp_din", ssp_din, e_din);
    chk("fifo_cnt", fifo_cnt, m_q.size());
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 8'h00, 8'h00);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((m_phase != 0 || m_q.size() > 0) && n < limit) begin
      step(0, 0, 8'h00, 8'h00);
      n++;
    end
    chk("drain_in_time", (n < limit), 1);
    idle(3);
  endtask

  function automatic logic [15:0] rx_at(input int k);
    if (rx_rd + k < rx_words.size()) return rx_words[rx_rd + k];
    return 16'hxxxx;
  endfunction

  task automatic compare_rx();
    chk("rx_count", rx_words.size() - rx_rd, exp_words.size() - ex_rd);
    while (rx_rd < rx_words.size() && ex_rd < exp_words.size()) begin
      $display("rx word %0h expected %0h", rx_words[rx_rd], exp_words[ex_rd]);
      chk("rx_word", rx_words[rx_rd], exp_words[ex_rd]);
      rx_rd++; ex_rd++;
    end
    rx_rd = rx_words.size();
    ex_rd = exp_words.size();
  endtask

  initial begin
    int n;
    // 1: reset then quiet outputs
    for (int k = 0; k < 3; k++) step(1, 0, 8'h00, 8'h00);
    idle(20);
    chk("t1_fifo_cnt", fifo_cnt, 0);
    chk("t1_drop_cnt", drop_cnt, 0);

    // 2: single pair, latency and bit pattern
    step(0, 1, 8'hA5, 8'h3C);
    step(0, 0, 8'h00, 8'h00);
    chk("t2_load_clk_low", ssp_clk, 0);
    step(0, 0, 8'h00, 8'h00);
    chk("t2_latency", ssp_clk, 1);
    chk("t2_frame_bit0", ssp_frame, 1);
    drain(200);
    chk("t2_word", rx_at(0), 16'hA53C);
    compare_rx();

    // 3: six back-to-back pushes, one dropped
    for (int k = 0; k < 6; k++) step(0, 1, 8'($urandom), 8'($urandom));
    chk("t3_drop_cnt", drop_cnt, 1);
    drain(600);
    chk("t3_rx_count", rx_words.size() - rx_rd, 5);
    compare_rx();

    // 4: push coinciding with a LOAD pop while full
    for (int k = 0; k < 5; k++) step(0, 1, 8'($urandom), 8'($urandom));
    chk("t4_full", fifo_cnt, 4);
    n = 0;
    while (m_phase != 1 && n < 200) begin step(0, 0, 8'h00, 8'h00); n++; end
    chk("t4_reach_load", (n < 200), 1);
    step(0, 1, 8'h5A, 8'hC3);
    chk("t4_cnt_kept", fifo_cnt, 4);
    chk("t4_no_drop", drop_cnt, 1);
    drain(800);
    compare_rx();

    // 5: reset mid-frame with pairs queued
    for (int k = 0; k < 4; k++) step(0, 1, 8'($urandom), 8'($urandom));
    n = 0;
    while (!(m_phase == 2 && m_el == 5 * CLK_DIV + 1) && n < 200) begin
      step(0, 0, 8'h00, 8'h00); n++;
    end
    chk("t5_reach_bit5", (n < 200), 1);
    step(1, 0, 8'h00, 8'h00);
    chk("t5_clk_zero", ssp_clk, 0);
    chk("t5_din_zero", ssp_din, 0);
    chk("t5_fifo_empty", fifo_cnt, 0);
    step(0, 1, 8'h01, 8'h80);
    drain(200);
    chk("t5_clean_word", rx_at(0), 16'h0180);
    compare_rx();

    // 6: overflow mark on the pair popped after a drop
    for (int k = 0; k < 6; k++) step(0, 1, 8'(8'h20 + k), 8'h00);
    drain(600);
    chk("t6_first", rx_at(0), 16'h2000);
    chk("t6_marked", rx_at(1), MARK_EN ? 16'h2101 : 16'h2100);
    chk("t6_unmarked", rx_at(2), 16'h2200);
    compare_rx();

    // 7: random traffic with occasional overflow
    for (int k = 0; k < 600; k++) begin
      step(0, ($urandom_range(0, 99) < 8), 8'($urandom), 8'($urandom));
    end
    drain(800);
    compare_rx();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
